// File: rtl/counter_sched_pkg.sv
// Shared types and the round-robin pick helper for the counter_sched interval-timer scheduler.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Widest request vector the pick helper accepts.
    localparam int unsigned RR_MAX = 32;

    // First set bit of req[n-1:0] at or above ptr, wrapping to bit 0; returns 0 when none is set.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req_vec,
                                            input int unsigned        n,
                                            input int unsigned        ptr);
        int unsigned j;
        int unsigned pick;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!found && req_vec[j[4:0]]) begin
                    found = 1'b1;
                    pick  = j;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/counter_sched_counter.sv
// Free-running up-counter with enable; the rst input clears it asynchronously (active high).
module counter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [BITS-1:0] count
);

    logic [BITS-1:0] count_q;
    logic [BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sched.sv
// Round-robin owner of one shared interval counter. Define COUNTER_SCHED_ABORT_EN to let the
// owner cancel its interval by dropping req during LOAD or RUN.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int N_REQ = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*BITS-1:0] len,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic [BITS-1:0]       count
);

    localparam int IW = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [BITS-1:0]    len_q, len_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               clear_q, clear_d;
    logic               en_q, en_d;

    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      next_ptr;
    logic [BITS-1:0]    count_w;
    logic               last_cycle;
    logic               abort;

    always_comb begin
        pick_idx = IW'(rr_pick(RR_MAX'(req), 32'(N_REQ), 32'(ptr_q)));
    end

    assign next_ptr   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
    assign last_cycle = (count_w == len_q - BITS'(1));

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort = ((state_q == S_LOAD) || (state_q == S_RUN)) && !req[idx_q];
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        grant_d = grant_q;
        done_d  = '0;
        clear_d = 1'b0;
        en_d    = en_q;

        if (abort) begin
            // Cancelled interval: release the owner, skip past it, leave the counter frozen.
            state_d = S_IDLE;
            grant_d = '0;
            en_d    = 1'b0;
            ptr_d   = next_ptr;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_d = 1'b0;
                    if (req != '0) begin
                        state_d           = S_LOAD;
                        idx_d             = pick_idx;
                        len_d             = len[int'(pick_idx)*BITS +: BITS];
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        clear_d           = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (len_q == '0) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                        en_d    = 1'b0;
                    end else begin
                        state_d = S_RUN;
                        en_d    = 1'b1;
                    end
                end
                S_RUN: begin
                    // The final enabled edge lands count on len as DONE is entered.
                    if (last_cycle) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                        en_d    = 1'b0;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    en_d    = 1'b0;
                    ptr_d   = next_ptr;
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            clear_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            clear_q <= clear_d;
            en_q    <= en_d;
        end
    end

    // clear_q is a flop, so the counter's async clear is glitch-free and spans exactly LOAD.
    counter #(
        .BITS(BITS)
    ) u_counter (
        .clk  (clock),
        .rst  (clear_q | ~reset),
        .en   (en_q),
        .count(count_w)
    );

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign count = count_w;

endmodule

// File: tb/tb_counter_sched.sv
// Randomised bench for counter_sched against a service-timeline reference model.
module tb_counter_sched;

    localparam int BITS  = 8;
    localparam int N_REQ = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*BITS-1:0] len;
    logic [N_REQ-1:0]      grant;
    logic [N_REQ-1:0]      done;
    logic                  busy;
    logic [BITS-1:0]       count;

    counter_sched #(.BITS(BITS), .N_REQ(N_REQ)) dut (
        .clock(clock),
        .reset(reset),
        .req  (req),
        .len  (len),
        .grant(grant),
        .done (done),
        .busy (busy),
        .count(count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: a service is described by owner, length and age in cycles since its grant.
    bit   m_active;
    int   m_idx, m_len, m_age, m_ptr, m_count;
    logic [7:0]       exp_q[$];
    logic [N_REQ-1:0] prev_grant;
    bit   auto_drop;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int len_of(input int i);
        return int'(len[i*BITS +: BITS]);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 0;
        m_len    = 0;
        m_age    = 0;
        m_ptr    = 0;
        m_count  = 0;
    endtask

    task automatic model_step();
        int old;
        if (!reset) begin
            model_reset();
            return;
        end
        if (!m_active) begin
            if (req != '0) begin
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % N_REQ]) m_idx = (m_ptr + k) % N_REQ;
                end
                m_active = 1'b1;
                m_len    = len_of(m_idx);
                m_age    = 0;
                exp_q.push_back(8'(m_idx));
            end
        end else begin
            old = m_age;
`ifdef COUNTER_SCHED_ABORT_EN
            if (old <= m_len && !req[m_idx]) begin
                m_active = 1'b0;
                m_ptr    = (m_idx + 1) % N_REQ;
                m_count  = old;
                return;
            end
`endif
            if (old == m_len + 1) begin
                m_active = 1'b0;
                m_ptr    = (m_idx + 1) % N_REQ;
                m_count  = m_len;
            end else begin
                m_age = old + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N_REQ-1:0] eg;
        eg = '0;
        if (m_active) eg[m_idx] = 1'b1;
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("done", 32'(done), (m_active && m_age == m_len + 1) ? 32'(eg) : 32'd0);
        check_eq("busy", 32'(busy), 32'(m_active));
        if (!m_active) check_eq("count_idle", 32'(count), 32'(m_count));
        else if (m_age > 0) check_eq("count_run", 32'(count), 32'(m_age - 1));
        if (grant != '0 && prev_grant == '0) begin
            if (exp_q.size() == 0) check_eq("order_extra", 32'(grant), 32'd0);
            else check_eq("order", 32'(grant), 32'd1 << exp_q.pop_front());
        end
        prev_grant = grant;
    endtask

    // One clock: model follows the DUT edge, outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
        if (auto_drop && m_active && m_age == m_len + 1) req[m_idx] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_len(input int i, input int v);
        len[i*BITS +: BITS] = BITS'(v);
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        check_eq("arst_grant", 32'(grant), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_count", 32'(count), 32'd0);
        model_reset();
        prev_grant = '0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        req        = '0;
        len        = '0;
        auto_drop  = 1'b1;
        prev_grant = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check_eq("reset_grant", 32'(grant), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_count", 32'(count), 32'd0);
        reset = 1'b1;

        // Single requester, len 5.
        set_len(0, 5);
        req = 4'b0001;
        run(12);

        // Two requesters served in turn.
        set_len(0, 3);
        set_len(2, 4);
        req = 4'b0101;
        run(18);

        // All requesters held high, len 1 each: strict rotation.
        auto_drop = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_len(i, 1);
        req = 4'b1111;
        run(22);
        req = '0;
        run(6);
        auto_drop = 1'b1;

        // Zero-length interval.
        set_len(1, 0);
        req = 4'b0010;
        run(6);

        // Reset in the middle of a run at count 2.
        set_len(0, 6);
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            if (m_active && m_age == 3) break;
            cycle();
        end
        check_eq("pre_reset_count", 32'(count), 32'd2);
        req = '0;
        async_reset();
        set_len(3, 2);
        req = 4'b1000;
        run(8);

        // Owner drops its request while running.
        set_len(1, 10);
        req = 4'b0010;
        run(4);
        req[1] = 1'b0;
        run(3);
        req = 4'b1011;
        run(30);

        // Full-scale interval: no wrap before done.
        set_len(2, (1 << BITS) - 1);
        req = 4'b0100;
        run((1 << BITS) + 6);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 25) req = req | N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            if (r >= 95 && m_active) req[m_idx] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                int v;
                v = int'($urandom_range(0, 9));
                if ($urandom_range(0, 199) == 0) v = (1 << BITS) - 1;
                set_len(int'($urandom_range(0, N_REQ - 1)), v);
            end
            if ($urandom_range(0, 299) == 0) async_reset();
            else cycle();
        end

        req = '0;
        run((1 << BITS) + 10);
        check_eq("order_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
